counter_30_0_reader: RTL and testbench
======================================

// Module: counter_30_0_reader
// PURPOSE
//  Read-side companion to the preset loader. The loader drives counter_30_0 through async preset/reset.
//  This block takes a stable snapshot of the counter's BCD outputs (tens, units) when a button is pressed.
//  It validates and converts the snapshot to binary, and flags expiry when the count reaches 00.
//  It sits beside counter_30_0 on the same clock. Its outputs feed display/status logic.
// PARAMETERS
//  SYNC_STAGES  2   button synchronizer depth (>=2)
//  MAX_VALUE    30  highest legal count; any higher snapshot is an over-range error
//  MAX_RETRY    3   mismatching sample pairs tolerated before an unstable error
// PORTS
//  clock          in   1  system clock, rising edge
//  reset_n        in   1  asynchronous, active-low reset
//  button         in   1  raw capture request, asynchronous, active-high
//  tens           in   2  counter BCD tens digit
//  units          in   4  counter BCD units digit
//  clear_expired  in   1  clears the expired flag
//  value          out  5  last valid snapshot, binary (0..MAX_VALUE)
//  snapshot_valid out  1  high once any valid snapshot has been taken
//  done           out  1  one-cycle pulse when a capture attempt ends (pass or fail)
//  error          out  1  last capture attempt failed; sticky until the next successful capture
//  error_code     out  2  01 invalid BCD, 10 over range, 11 unstable, 00 none
//  busy           out  1  high whenever the FSM is not in IDLE
//  expired        out  1  sticky: counter observed at 00 on two consecutive cycles
// BEHAVIOUR
//  Reset: all outputs 0; FSM in IDLE; retry count 0.
//   - Sync chain and edge-detect register reset to 1.
//   - A button held through reset produces no press; it must be released and pressed again.
//  Press: rising edge at the synchronizer output, registered into a one-cycle press pulse.
//   - The press pulse is seen in cycle N.
//  FSM states: IDLE, SAMPLE, COMPARE, CONVERT.
//   - IDLE: press -> SAMPLE; retry count cleared. Presses while busy are dropped, not queued.
//   - SAMPLE: register {tens,units} into s_a -> COMPARE.
//   - COMPARE, live {tens,units}==s_a -> CONVERT.
//   - COMPARE, mismatch, retry < MAX_RETRY-1: increment retry -> SAMPLE.
//   - COMPARE, mismatch, retry == MAX_RETRY-1: error=1, code 11, done -> IDLE.
//   - CONVERT: validate s_a, update outputs, done -> IDLE.
//  Validation, checked in this order:
//   - units>9: error=1, code 01.
//   - tens*10+units > MAX_VALUE: error=1, code 10.
//   - Otherwise: value=tens*10+units, snapshot_valid=1, error=0, code 00.
//   - tens*10+units is computed at 6 bits, then truncated to 5 bits for value.
//  On any failure, value and snapshot_valid keep their previous contents.
//  Latency, stable input: press pulse cycle N, SAMPLE N+1, COMPARE N+2, CONVERT N+3.
//   - value, error and done update at the edge ending N+3.
//   - done is high for exactly 1 cycle. busy is high N+1..N+3.
//  Each retry adds 2 cycles. Worst-case unstable failure: done after 2*MAX_RETRY cycles.
//  Expiry monitor runs in every state, independent of the FSM.
//   - A zero_seen register is set when {tens,units}==0.
//   - expired sets when zero_seen && {tens,units}==0.
//   - clear_expired drops expired; a set in the same cycle as clear wins.
//  reset_n asserted mid-capture: FSM aborts immediately, no done pulse, all outputs return to reset values.
// TESTING
//  1. tens=2, units=5 held, one press -> done 4 cycles after the press pulse, value=25, snapshot_valid=1, error=0.
//  2. units=4'hA -> done, error=1, code 01, value unchanged.
//     Then tens=3, units=1 -> error=1, code 10.
//  3. units toggled every cycle during capture -> done after 6 cycles, code 11.
//     Repeat with toggling stopped after 1 mismatch -> success, done 2 cycles later than case 1.
//  4. Counter at 00 for 1 cycle -> expired stays 0; at 00 for 2 cycles -> expired=1.
//     clear_expired asserted while the counter is still 00 -> expired stays 1.
//  5. Second press while busy=1 -> ignored: only one done pulse, no extra capture.
//  6. reset_n pulsed low during COMPARE -> outputs 0 at once, no done pulse.
//     Button held through reset -> no capture until released and pressed again.

Source files
------------

// File: rtl/counter_30_0_reader.sv
// Snapshot reader for the counter_30_0 BCD outputs.
// Synchronizes a raw button, takes a double-sampled snapshot of {tens,units},
// validates and converts it to binary, and monitors the count for expiry at 00.
// Ports:
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   button               raw asynchronous capture request
//   tens, units          counter BCD digits
//   clear_expired        drops the sticky expired flag
//   value                last valid snapshot in binary
//   snapshot_valid       a valid snapshot has been taken since reset
//   done                 one-cycle pulse at the end of each capture attempt
//   error, error_code    result of the last attempt (01 BCD, 10 range, 11 unstable)
//   busy                 capture FSM not idle
//   expired              sticky: counter seen at 00 on two consecutive cycles
module counter_30_0_reader #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_VALUE   = 30,
    parameter int unsigned MAX_RETRY   = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       button,
    input  logic [1:0] tens,
    input  logic [3:0] units,
    input  logic       clear_expired,
    output logic [4:0] value,
    output logic       snapshot_valid,
    output logic       done,
    output logic       error,
    output logic [1:0] error_code,
    output logic       busy,
    output logic       expired
);

    localparam int unsigned SNAP_W  = 6;
    localparam int unsigned VALUE_W = 5;
    localparam int unsigned RETRY_W = (MAX_RETRY > 2) ? $clog2(MAX_RETRY) : 1;

    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_BCD      = 2'b01;
    localparam logic [1:0] CODE_RANGE    = 2'b10;
    localparam logic [1:0] CODE_UNSTABLE = 2'b11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SAMPLE  = 2'd1,
        COMPARE = 2'd2,
        CONVERT = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_prev_q;
    logic                   press_q;

    logic [SNAP_W-1:0]      snap;
    logic [SNAP_W-1:0]      s_a_q;
    logic [SNAP_W-1:0]      s_a_d;
    logic [SNAP_W-1:0]      s_a_sum;
    logic [RETRY_W-1:0]     retry_q;
    logic [RETRY_W-1:0]     retry_d;

    logic [VALUE_W-1:0]     value_d;
    logic                   valid_d;
    logic                   done_d;
    logic                   error_d;
    logic [1:0]             code_d;

    logic                   zero_now;
    logic                   zero_seen_q;

    assign snap     = {tens, units};
    assign zero_now = (snap == '0);
    assign s_a_sum  = SNAP_W'(s_a_q[5:4]) * SNAP_W'(10) + SNAP_W'(s_a_q[3:0]);

    // Button synchronizer and rising-edge press pulse; the chain resets high
    // so a button held through reset never looks like a new press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q      <= '1;
            sync_prev_q <= 1'b1;
            press_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], button};
            sync_prev_q <= sync_q[SYNC_STAGES-1];
            press_q     <= sync_q[SYNC_STAGES-1] & ~sync_prev_q;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (press_q) state_d = SAMPLE;
            SAMPLE:  state_d = COMPARE;
            COMPARE: begin
                if (snap == s_a_q) begin
                    state_d = CONVERT;
                end else if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                    state_d = IDLE;
                end else begin
                    state_d = SAMPLE;
                end
            end
            CONVERT: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath and output next values
    always_comb begin
        s_a_d   = s_a_q;
        retry_d = retry_q;
        value_d = value;
        valid_d = snapshot_valid;
        error_d = error;
        code_d  = error_code;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (press_q) retry_d = '0;
            end
            SAMPLE: begin
                s_a_d = snap;
            end
            COMPARE: begin
                if (snap != s_a_q) begin
                    if (retry_q == RETRY_W'(MAX_RETRY - 1)) begin
                        error_d = 1'b1;
                        code_d  = CODE_UNSTABLE;
                        done_d  = 1'b1;
                    end else begin
                        retry_d = retry_q + RETRY_W'(1);
                    end
                end
            end
            CONVERT: begin
                done_d = 1'b1;
                // BCD validity takes priority over the range check
                if (s_a_q[3:0] > 4'd9) begin
                    error_d = 1'b1;
                    code_d  = CODE_BCD;
                end else if (s_a_sum > SNAP_W'(MAX_VALUE)) begin
                    error_d = 1'b1;
                    code_d  = CODE_RANGE;
                end else begin
                    value_d = VALUE_W'(s_a_sum);
                    valid_d = 1'b1;
                    error_d = 1'b0;
                    code_d  = CODE_NONE;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and datapath; busy follows the next state so it is
    // high exactly while the FSM is out of IDLE.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s_a_q          <= '0;
            retry_q        <= '0;
            value          <= '0;
            snapshot_valid <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            error_code     <= CODE_NONE;
            busy           <= 1'b0;
        end else begin
            s_a_q          <= s_a_d;
            retry_q        <= retry_d;
            value          <= value_d;
            snapshot_valid <= valid_d;
            done           <= done_d;
            error          <= error_d;
            error_code     <= code_d;
            busy           <= (state_d != IDLE);
        end
    end

    // Expiry monitor, independent of the FSM; a set beats a same-cycle clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            zero_seen_q <= 1'b0;
            expired     <= 1'b0;
        end else begin
            zero_seen_q <= zero_now;
            expired     <= (zero_seen_q & zero_now) | (expired & ~clear_expired);
        end
    end

endmodule

// File: tb/tb_counter_30_0_reader.sv
// Directed bench for counter_30_0_reader: a table of capture vectors plus
// hand-written reset, expiry and mid-capture reset sequences.
module tb_counter_30_0_reader;

    logic       clock;
    logic       reset_n;
    logic       button;
    logic [1:0] tens;
    logic [3:0] units;
    logic       clear_expired;
    logic [4:0] value;
    logic       snapshot_valid;
    logic       done;
    logic       error;
    logic [1:0] error_code;
    logic       busy;
    logic       expired;

    int n_checks = 0;
    int n_pass   = 0;

    counter_30_0_reader dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .button         (button),
        .tens           (tens),
        .units          (units),
        .clear_expired  (clear_expired),
        .value          (value),
        .snapshot_valid (snapshot_valid),
        .done           (done),
        .error          (error),
        .error_code     (error_code),
        .busy           (busy),
        .expired        (expired)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [1:0] tens;
        logic [3:0] units;
        int         mode;      // 0 hold, 1 toggle units every cycle, 2 toggle once, 3 double press
        int         done_edge; // edge after button rise where done is first seen
        int         n_done;
        int         n_busy;
        int         value;
        int         valid;
        int         err;
        int         code;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " value"}, int'(value), 0);
        check({tag, " snapshot_valid"}, int'(snapshot_valid), 0);
        check({tag, " done"}, int'(done), 0);
        check({tag, " error"}, int'(error), 0);
        check({tag, " error_code"}, int'(error_code), 0);
        check({tag, " busy"}, int'(busy), 0);
        check({tag, " expired"}, int'(expired), 0);
    endtask

    // Raise button and watch 24 edges, recording done and busy activity.
    task automatic run_capture(input logic [1:0] t, input logic [3:0] u, input int mode,
                               output int first_done, output int n_done, output int n_busy);
        first_done = 0;
        n_done     = 0;
        n_busy     = 0;
        @(negedge clock);
        tens   = t;
        units  = u;
        button = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(posedge clock);
            #1;
            if (done) begin
                n_done++;
                if (first_done == 0) first_done = k;
            end
            if (busy) n_busy++;
            @(negedge clock);
            case (mode)
                1: units = (units == 4'd1) ? 4'd2 : 4'd1;
                2: if (k == 5) units = (units == 4'd1) ? 4'd2 : 4'd1;
                3: begin
                    if (k == 1) button = 1'b0;
                    if (k == 2) button = 1'b1;
                    if (k == 4) button = 1'b0;
                end
                default: ;
            endcase
            if (mode != 3 && k == 3) button = 1'b0;
        end
    endtask

    initial begin
        int fd, nd, nb;

        vecs[0] = '{2'd2, 4'd5,  0,  7, 1, 3, 25, 1, 0, 0};
        vecs[1] = '{2'd0, 4'hA,  0,  7, 1, 3, 25, 1, 1, 1};
        vecs[2] = '{2'd3, 4'd1,  0,  7, 1, 3, 25, 1, 1, 2};
        vecs[3] = '{2'd3, 4'd0,  0,  7, 1, 3, 30, 1, 0, 0};
        vecs[4] = '{2'd3, 4'hF,  0,  7, 1, 3, 30, 1, 1, 1};
        vecs[5] = '{2'd2, 4'd1,  1, 10, 1, 6, 30, 1, 1, 3};
        vecs[6] = '{2'd2, 4'd1,  2,  9, 1, 5, 22, 1, 0, 0};
        vecs[7] = '{2'd1, 4'd9,  3,  7, 1, 3, 19, 1, 0, 0};
        vecs[8] = '{2'd1, 4'd2,  0,  7, 1, 3, 12, 1, 0, 0};

        reset_n       = 1'b0;
        button        = 1'b0;
        tens          = 2'd1;
        units         = 4'd5;
        clear_expired = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        @(negedge clock);
        reset_n = 1'b1;
        repeat (4) @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            run_capture(vecs[i].tens, vecs[i].units, vecs[i].mode, fd, nd, nb);
            check($sformatf("v%0d done_edge", i), fd, vecs[i].done_edge);
            check($sformatf("v%0d done_count", i), nd, vecs[i].n_done);
            check($sformatf("v%0d busy_cycles", i), nb, vecs[i].n_busy);
            check($sformatf("v%0d value", i), int'(value), vecs[i].value);
            check($sformatf("v%0d snapshot_valid", i), int'(snapshot_valid), vecs[i].valid);
            check($sformatf("v%0d error", i), int'(error), vecs[i].err);
            check($sformatf("v%0d error_code", i), int'(error_code), vecs[i].code);
        end
        check("no expiry during captures", int'(expired), 0);

        // Reset asserted in COMPARE with the button still held
        @(negedge clock);
        tens   = 2'd2;
        units  = 4'd7;
        button = 1'b1;
        repeat (5) @(posedge clock);
        @(negedge clock);
        check("busy before mid reset", int'(busy), 1);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid reset");
        @(negedge clock);
        reset_n = 1'b1;
        nd = 0;
        nb = 0;
        for (int k = 0; k < 24; k++) begin
            @(posedge clock);
            #1;
            if (done) nd++;
            if (busy) nb++;
        end
        check("held button done count", nd, 0);
        check("held button busy cycles", nb, 0);
        @(negedge clock);
        button = 1'b0;
        repeat (5) @(negedge clock);
        run_capture(2'd2, 4'd7, 0, fd, nd, nb);
        check("repress done_edge", fd, 7);
        check("repress done_count", nd, 1);
        check("repress value", int'(value), 27);
        check("repress snapshot_valid", int'(snapshot_valid), 1);
        check("repress error", int'(error), 0);

        // Expiry monitor
        @(negedge clock);
        tens  = 2'd0;
        units = 4'd0;
        @(negedge clock);
        tens  = 2'd1;
        units = 4'd5;
        repeat (2) @(posedge clock);
        #1;
        check("zero one cycle", int'(expired), 0);
        @(negedge clock);
        tens  = 2'd0;
        units = 4'd0;
        @(negedge clock);
        @(posedge clock);
        #1;
        check("zero two cycles", int'(expired), 1);
        @(negedge clock);
        tens  = 2'd1;
        units = 4'd5;
        @(posedge clock);
        #1;
        check("expired sticky", int'(expired), 1);
        @(negedge clock);
        clear_expired = 1'b1;
        @(posedge clock);
        #1;
        check("clear expired", int'(expired), 0);
        @(negedge clock);
        clear_expired = 1'b0;
        tens  = 2'd0;
        units = 4'd0;
        repeat (2) @(posedge clock);
        #1;
        check("re-expire", int'(expired), 1);
        @(negedge clock);
        clear_expired = 1'b1;
        @(posedge clock);
        #1;
        check("set beats clear", int'(expired), 1);
        @(negedge clock);
        units = 4'd5;
        @(posedge clock);
        #1;
        check("clear after zero ends", int'(expired), 0);
        @(negedge clock);
        clear_expired = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
